// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (core and host loader).
// Define HOST_PRIO_EN to give the host fixed priority instead of round-robin.
module dmem_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 32,
   parameter int READ_LAT = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_gnt,
   output logic          h_ack,
   output logic [DW-1:0] h_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg;
   logic            owner_reg;
   logic            last_owner_reg;
   logic            we_reg;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wdata_reg;
   logic            sel_host;
   logic            capture;
   logic [1:0]      ack_vec;
   logic [DW-1:0]   rdata_reg [2];

   always_comb begin
      state_next = state_reg;
      c_gnt      = 1'b0;
      h_gnt      = 1'b0;
`ifdef HOST_PRIO_EN
      sel_host   = h_req;
`else
      // The port that was not served last wins a tie.
      sel_host   = h_req && (!c_req || !last_owner_reg);
`endif
      case (state_reg)
         IDLE: begin
            if (c_req || h_req) begin
               state_next = ISSUE;
               h_gnt      = sel_host;
               c_gnt      = !sel_host;
            end
         end
         ISSUE:   state_next = we_reg ? DONE : WAIT;
         WAIT:    if (cnt_reg == 4'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b1;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (c_req || h_req) begin
                  owner_reg <= sel_host;
                  we_reg    <= sel_host ? h_we    : c_we;
                  addr_reg  <= sel_host ? h_addr  : c_addr;
                  wdata_reg <= sel_host ? h_wdata : c_wdata;
               end
            end
            // WAIT spans READ_LAT cycles; data is taken in its last one.
            ISSUE:   cnt_reg <= LAT_M1;
            WAIT:    cnt_reg <= cnt_reg - 4'd1;
            DONE:    last_owner_reg <= owner_reg;
            default: ;
         endcase
      end
   end

   assign capture = (state_reg == WAIT) && (cnt_reg == 4'd0);

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_ff @(posedge clock) begin
         if (!reset_n)
            rdata_reg[gi] <= '0;
         else if (capture && (owner_reg == 1'(gi)))
            rdata_reg[gi] <= mem_rdata;
      end
      assign ack_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
   end

   assign c_ack     = ack_vec[0];
   assign h_ack     = ack_vec[1];
   assign c_rdata   = rdata_reg[0];
   assign h_rdata   = rdata_reg[1];
   assign mem_en    = (state_reg == ISSUE);
   assign mem_we    = (state_reg == ISSUE) && we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign busy      = (state_reg != IDLE);
   assign owner     = owner_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a READ_LAT=3 instance and a READ_LAT=1 instance,
// each with its own small latency-accurate memory model.
module tb_dmem_arbiter;

   localparam int LAT = 3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;

   logic        c_req = 0, c_we = 0, h_req = 0, h_we = 0;
   logic [15:0] c_addr = 0, h_addr = 0;
   logic [31:0] c_wdata = 0, h_wdata = 0;
   logic        c_gnt, c_ack, h_gnt, h_ack, mem_en, mem_we, busy, owner;
   logic [31:0] c_rdata, h_rdata, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;

   logic        l1_c_req = 0;
   logic [15:0] l1_c_addr = 0;
   logic        l1_c_gnt, l1_c_ack, l1_h_gnt, l1_h_ack, l1_mem_en, l1_mem_we, l1_busy, l1_owner;
   logic [31:0] l1_c_rdata, l1_h_rdata, l1_mem_wdata, l1_mem_rdata;
   logic [15:0] l1_mem_addr;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_c_rd = 0;
   logic [31:0] exp_h_rd = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(.AW(16), .DW(32), .READ_LAT(LAT)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_ack(c_ack), .c_rdata(c_rdata),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_gnt(h_gnt), .h_ack(h_ack), .h_rdata(h_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   dmem_arbiter #(.AW(16), .DW(32), .READ_LAT(1)) u_dut_l1 (
      .clock(clock), .reset_n(reset_n),
      .c_req(l1_c_req), .c_we(1'b0), .c_addr(l1_c_addr), .c_wdata(32'h0),
      .c_gnt(l1_c_gnt), .c_ack(l1_c_ack), .c_rdata(l1_c_rdata),
      .h_req(1'b0), .h_we(1'b0), .h_addr(16'h0), .h_wdata(32'h0),
      .h_gnt(l1_h_gnt), .h_ack(l1_h_ack), .h_rdata(l1_h_rdata),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(l1_mem_rdata), .busy(l1_busy), .owner(l1_owner)
   );

   // Memory models: read data appears exactly LAT cycles after the enable cycle, for one cycle.
   logic [31:0] ram0 [65536];
   logic [31:0] pipe0 [LAT];
   always @(posedge clock) begin
      if (!reset_n) ram0[16'h0010] <= 32'hDEADBEEF;
      else if (mem_en && mem_we) ram0[mem_addr] <= mem_wdata;
      pipe0[0] <= (mem_en && !mem_we) ? ram0[mem_addr] : 32'h0;
      for (int i = 1; i < LAT; i++) pipe0[i] <= pipe0[i-1];
   end
   assign mem_rdata = pipe0[LAT-1];

   logic [31:0] ram1 [65536];
   logic [31:0] pipe1;
   always @(posedge clock) begin
      if (!reset_n) begin
         ram1[16'h0001] <= 32'hA1A1A1A1;
         ram1[16'h0002] <= 32'hB2B2B2B2;
      end else if (l1_mem_en && l1_mem_we) ram1[l1_mem_addr] <= l1_mem_wdata;
      pipe1 <= (l1_mem_en && !l1_mem_we) ? ram1[l1_mem_addr] : 32'h0;
   end
   assign l1_mem_rdata = pipe1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 0; c_req = 0; h_req = 0; l1_c_req = 0;
      repeat (2) @(negedge clock);
      reset_n = 1; exp_c_rd = 0; exp_h_rd = 0;
      #1;
      check_val("rst_busy_owner", 32'({busy, owner}), 32'h0);
      check_val("rst_mem", 32'({mem_en, mem_we}) | 32'(mem_addr) | mem_wdata, 32'h0);
      check_val("rst_c_rdata", c_rdata, 32'h0);
      check_val("rst_h_rdata", h_rdata, 32'h0);
      check_val("rst_gnt_ack", 32'({c_gnt, h_gnt, c_ack, h_ack}), 32'h0);
   endtask

   // One isolated access: checks grant, issue cycle, wait length, ack cycle and rdata retention.
   task automatic run_access(input bit host, input bit we, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
      @(negedge clock);
      if (host) begin h_req = 1; h_we = we; h_addr = addr; h_wdata = wdata; end
      else      begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
      #1;
      check_val("gnt", 32'({c_gnt, h_gnt}), host ? 32'd1 : 32'd2);
      @(negedge clock);
      c_req = 0; h_req = 0;
      #1;
      check_val("issue_en_we", 32'({mem_en, mem_we}), {30'b0, 1'b1, we});
      check_val("issue_addr", 32'(mem_addr), 32'(addr));
      if (we) check_val("issue_wdata", mem_wdata, wdata);
      check_val("issue_owner_busy", 32'({owner, busy}), {30'b0, host, 1'b1});
      repeat (we ? 0 : LAT) begin
         @(negedge clock); #1;
         check_val("wait_quiet", 32'({mem_en, c_ack, h_ack}), 32'h0);
      end
      @(negedge clock); #1;
      check_val("ack", 32'({c_ack, h_ack}), host ? 32'd1 : 32'd2);
      if (!we) begin
         if (host) exp_h_rd = exp_rd;
         else      exp_c_rd = exp_rd;
      end
      check_val("c_rdata", c_rdata, exp_c_rd);
      check_val("h_rdata", h_rdata, exp_h_rd);
      $display("%s %s addr=0x%04h wdata=0x%08h c_rdata=0x%08h h_rdata=0x%08h",
               host ? "host" : "core", we ? "write" : "read ", addr, wdata, c_rdata, h_rdata);
      @(negedge clock); #1;
      check_val("idle_after", 32'({busy, c_ack, h_ack}), 32'h0);
   endtask

   logic [1:0] exp_order [4];
   int         grants;
   int         cyc;
   int         last_cyc;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef HOST_PRIO_EN
      exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
      do_reset();

      run_access(0, 0, 16'h0010, 32'h0, 32'hDEADBEEF);
      run_access(1, 1, 16'h0020, 32'h12345678, 32'h0);
      run_access(0, 0, 16'h0020, 32'h0, 32'h12345678);
      run_access(0, 1, 16'h0030, 32'hCAFEF00D, 32'h0);
      run_access(1, 0, 16'h0030, 32'h0, 32'hCAFEF00D);

      // Reset in the middle of a core read's WAIT phase.
      @(negedge clock);
      c_req = 1; c_we = 0; c_addr = 16'h0010;
      #1 check_val("rw_gnt", 32'(c_gnt), 32'd1);
      @(negedge clock); c_req = 0;
      @(negedge clock); #1 check_val("rw_in_wait", 32'({busy, mem_en}), 32'd2);
      @(negedge clock); reset_n = 0;
      @(negedge clock); reset_n = 1; exp_c_rd = 0; exp_h_rd = 0;
      #1;
      check_val("rw_busy", 32'(busy), 32'h0);
      check_val("rw_c_rdata", c_rdata, 32'h0);
      check_val("rw_en_ack", 32'({mem_en, c_ack}), 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock); #1;
         check_val("rw_no_ack", 32'({c_ack, busy}), 32'h0);
      end
      run_access(1, 0, 16'h0020, 32'h0, 32'h12345678);

      // Contention: both requests held high from reset.
      do_reset();
      @(negedge clock);
      c_req = 1; h_req = 1; c_we = 0; h_we = 0; c_addr = 16'h0010; h_addr = 16'h0020;
      grants = 0; cyc = 0; last_cyc = 0;
      while (grants < 4 && cyc < 60) begin
         #1;
         if (c_gnt || h_gnt) begin
            check_val($sformatf("grant_order%0d", grants), 32'({c_gnt, h_gnt}), 32'(exp_order[grants]));
            if (grants > 0) check_val("grant_spacing", 32'(cyc - last_cyc), 32'(LAT + 3));
            $display("contention grant %0d to %s at cycle %0d", grants, h_gnt ? "host" : "core", cyc);
            last_cyc = cyc;
            grants++;
         end
         @(negedge clock);
         cyc++;
      end
      c_req = 0; h_req = 0;
      check_val("grant_count", 32'(grants), 32'd4);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (!busy) break;
         @(negedge clock);
      end
      check_val("drain", 32'(busy), 32'h0);

      // READ_LAT=1 instance: back-to-back core reads with req held.
      @(negedge clock);
      for (int i = 0; i < 9; i++) begin
         l1_c_req  = (i <= 4);
         l1_c_addr = (i == 0) ? 16'h0001 : 16'h0002;
         #1;
         check_val($sformatf("l1_gnt%0d", i), 32'(l1_c_gnt), 32'(i == 0 || i == 4));
         check_val($sformatf("l1_ack%0d", i), 32'(l1_c_ack), 32'(i == 3 || i == 7));
         if (i == 3) check_val("l1_rdata1", l1_c_rdata, 32'hA1A1A1A1);
         if (i == 7) check_val("l1_rdata2", l1_c_rdata, 32'hB2B2B2B2);
         if (l1_c_ack) $display("lat1 core read ack at cycle %0d rdata=0x%08h", i, l1_c_rdata);
         @(negedge clock);
      end
      #1;
      check_val("l1_host_side", 32'({l1_h_gnt, l1_h_ack, l1_busy, l1_owner}) | l1_h_rdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor core (load/store micro-states) and the host loader (image in, downsampled result out).
- Serialises accesses, applies the fixed memory read latency and returns a one-cycle completion pulse with read data to the served port.
- Sits between the controller/datapath memory interface and the data RAM.

Parameters:
AW, 16, address width
DW, 32, data width
READ_LAT, 3, memory read latency in cycles from the enable cycle to valid mem_rdata; legal range 1..15

Ports:
clock  in  1  system clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
c_req  in  1  core request; level, held until c_gnt
c_we  in  1  core write (1) / read (0)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_gnt  out  1  core request accepted; operands latched this cycle
c_ack  out  1  core access complete, 1-cycle pulse
c_rdata  out  DW  core read data; valid with c_ack
h_req  in  1  host request
h_we  in  1  host write/read
h_addr  in  AW  host address
h_wdata  in  DW  host write data
h_gnt  out  1  host request accepted
h_ack  out  1  host access complete
h_rdata  out  DW  host read data
mem_en  out  1  memory access strobe, 1 cycle
mem_we  out  1  memory write enable; valid with mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE
owner  out  1  port being served: 0 = core, 1 = host

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset (reset_n=0 at a posedge):
  - state=IDLE; all outputs 0.
  - c_rdata = h_rdata = 0; last_owner = 1 (host), so the core wins the first contention.
  - Reset mid-access abandons the access; mem_en is low from the next cycle.
- IDLE:
  - If any req is high, select a port. x_gnt is combinational in IDLE only; the selected port's addr/we/wdata are latched at this edge; next state ISSUE.
  - With both requests high, round-robin: the port not equal to last_owner wins.
  - A requester may drop req or present a new request the cycle after gnt.
- ISSUE:
  - mem_en=1, and mem_we/mem_addr/mem_wdata come from the latched values; owner is valid.
  - Write: next state DONE.
  - Read with READ_LAT=1: capture mem_rdata at the end of the next cycle (treated as a single WAIT).
  - Read otherwise: next state WAIT.
- WAIT:
  - Counter runs READ_LAT cycles after ISSUE; mem_en=0.
  - At the end of the cycle READ_LAT after ISSUE, mem_rdata is registered into the owner's rdata; next state DONE.
- DONE:
  - Owner's ack=1 for exactly one cycle; last_owner <= owner; next state IDLE.
- Latency, with gnt in cycle T:
  - Write: mem_en at T+1, ack at T+2.
  - Read: mem_en at T+1, data captured at T+1+READ_LAT, ack at T+2+READ_LAT.
  - Minimum gap between grants is one IDLE cycle after DONE.
- Register retention:
  - x_rdata holds its value until that port's next read completes.
  - Writes do not change x_rdata.
- Requests during a non-IDLE state are not granted. They are evaluated in the next IDLE cycle, so a requester that keeps req high is served with no lost request.
- No starvation: under continuous requests from both ports, grants alternate.

Optional Feature:
- HOST_PRIO_EN defined: fixed priority; the host wins every contention and last_owner is ignored for selection. This keeps the bulk image load ahead of the core while status is not running.
- HOST_PRIO_EN undefined: round-robin as specified above.

Test Plan:
- Core read only, READ_LAT=3, c_addr=0x0010, memory model returns 0xDEADBEEF -> c_gnt at T; mem_en/mem_addr=0x0010 at T+1; c_ack and c_rdata=0xDEADBEEF at T+5; h_ack never asserted.
- Host write h_addr=0x0020, h_wdata=0x12345678 -> mem_en=1, mem_we=1 at T+1; h_ack at T+2. A following core read of 0x0020 returns 0x12345678.
- c_req and h_req both held high after reset, four accesses -> grant order core, host, core, host. With HOST_PRIO_EN: host, host, host, host until h_req drops.
- reset_n=0 during WAIT of a core read -> next cycle state IDLE, busy=0, c_rdata=0, no c_ack. A new h_req afterwards is granted normally.
- READ_LAT=1 build, back-to-back core reads of 0x0001 then 0x0002 -> acks 3 cycles after each gnt; second gnt occurs exactly 1 cycle after the first ack (one IDLE cycle).
